dm_wait_mem: RTL and testbench

- Parametrised, synthesisable data-memory block for the pipelined MIPS core; the next generation of the flat behavioural data array.
- Adds a req/ready handshake, a programmable wait-state count, address-range checking and a hardware zero-fill sequence after reset.
- Sits behind the M-stage bridge; the core stalls on !req_ready.

---
 rtl/dm_pkg.sv | 42 ++++
 rtl/dm_wait_mem_array.sv | 30 +++
 rtl/dm_wait_mem.sv | 187 ++++++++++++++++++
 tb/tb_dm_wait_mem.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the wait-state data memory:
// FSM state encoding, byte-lane width, lane merge and address range check.
package dm_pkg;

  typedef enum logic [1:0] {
    CLR  = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // The merge helper works on the widest supported word; callers resize in and out.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef logic [MAX_DATA_W-1:0] wide_word_t;
  typedef logic [MAX_BE_W-1:0]   wide_be_t;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic wide_word_t merge_lanes(input wide_word_t old_word,
                                             input wide_word_t new_word,
                                             input wide_be_t   byteen);
    wide_word_t merged;
    for (int b = 0; b < MAX_BE_W; b++) begin
      merged[b*8 +: 8] = byteen[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    end
    return merged;
  endfunction

  // Unsigned offset; addresses below base wrap to a huge offset and fail the compare.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] span_bytes);
    logic [31:0] offset;
    offset = addr - base;
    return ({1'b0, offset} < span_bytes);
  endfunction

endpackage

// File: rtl/dm_wait_mem_array.sv
// Single-port synchronous word array with per-byte-lane write enables.
// Read is registered and read-first: o_rdata shows the word as it was before a same-edge write.
module dm_wait_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  localparam int BE_W  = DATA_W / 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [BE_W-1:0]   i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_wait_mem.sv
// Data memory with req/ready handshake, programmable wait states, range check and zero-fill.
// Optional write log outputs are enabled by defining DM_WRITE_LOG_EN.
module dm_wait_mem
  import dm_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 4096,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2,
  localparam int         BE_W        = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [BE_W-1:0]   req_byteen,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
`ifdef DM_WRITE_LOG_EN
  ,
  output logic              log_valid,
  output logic [31:0]       log_addr,
  output logic [DATA_W-1:0] log_data
`endif
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          LANE_SH   = $clog2(BE_W);
  localparam logic [32:0] SPAN      = 33'(DEPTH) * 33'(BE_W);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            r_state;
  state_t            w_next_state;
  logic [AW-1:0]     r_ptr;
  logic [3:0]        r_cnt;
  logic [31:0]       r_addr;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata_hold;
  logic              r_init_done;

  logic [31:0]       w_acc_addr;
  logic [BE_W-1:0]   w_acc_be;
  logic [DATA_W-1:0] w_acc_wdata;
  logic              w_acc_in_range;
  logic [31:0]       w_acc_offset;
  logic [AW-1:0]     w_acc_index;
  logic              w_commit;
  logic [BE_W-1:0]   w_arr_we;
  logic [AW-1:0]     w_arr_addr;
  logic [DATA_W-1:0] w_arr_wdata;
  logic [DATA_W-1:0] w_arr_rdata;
  logic [DATA_W-1:0] w_resp_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= CLR;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      CLR:     if (r_ptr == AW'(DEPTH - 1)) w_next_state = IDLE;
      IDLE:    if (req_valid) w_next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (r_cnt == 4'd1) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = CLR;
    endcase
  end

  // With zero wait states the commit edge is the acceptance edge, so use the live request.
  always_comb begin
    if (r_state == IDLE) begin
      w_acc_addr  = req_addr;
      w_acc_be    = req_byteen;
      w_acc_wdata = req_wdata;
    end else begin
      w_acc_addr  = r_addr;
      w_acc_be    = r_be;
      w_acc_wdata = r_wdata;
    end
  end

  assign w_acc_in_range = addr_in_range(w_acc_addr, ADDR_BASE, SPAN);
  assign w_acc_offset   = w_acc_addr - ADDR_BASE;
  assign w_acc_index    = AW'(w_acc_offset >> LANE_SH);
  assign w_commit       = (w_next_state == RESP) && (r_state != RESP);

  always_comb begin
    if (r_state == CLR) begin
      w_arr_we    = '1;
      w_arr_addr  = r_ptr;
      w_arr_wdata = '0;
    end else begin
      w_arr_we    = (w_commit && w_acc_in_range) ? w_acc_be : '0;
      w_arr_addr  = w_acc_index;
      w_arr_wdata = w_acc_wdata;
    end
  end

  dm_wait_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_addr  (w_arr_addr),
    .i_wdata (w_arr_wdata),
    .o_rdata (w_arr_rdata)
  );

  // In RESP the array output holds the pre-commit word; rebuild the merged word from it.
  assign w_resp_word = r_err ? '0
                     : DATA_W'(merge_lanes(wide_word_t'(w_arr_rdata),
                                           wide_word_t'(r_wdata),
                                           wide_be_t'(r_be)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_rdata_hold <= '0;
      r_init_done  <= 1'b0;
    end else begin
      if (r_state == CLR) begin
        r_ptr <= r_ptr + AW'(1);
        if (w_next_state == IDLE) r_init_done <= 1'b1;
      end
      if (r_state == IDLE && req_valid) begin
        r_addr  <= req_addr;
        r_be    <= req_byteen;
        r_wdata <= req_wdata;
        r_cnt   <= WAIT_INIT;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) r_err <= !w_acc_in_range;
      if (r_state == RESP) r_rdata_hold <= w_resp_word;
    end
  end

  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == RESP);
    rsp_rdata = (r_state == RESP) ? w_resp_word : r_rdata_hold;
    rsp_err   = r_err;
    init_done = r_init_done;
  end

`ifdef DM_WRITE_LOG_EN
  logic              r_log_valid;
  logic [31:0]       r_log_addr;
  logic [DATA_W-1:0] r_log_data;

  // Captured while RESP presents the merged word, so the pulse follows RESP by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_log_valid <= 1'b0;
      r_log_addr  <= '0;
      r_log_data  <= '0;
    end else begin
      r_log_valid <= (r_state == RESP) && !r_err && (r_be != '0);
      if ((r_state == RESP) && !r_err && (r_be != '0)) begin
        r_log_addr <= r_addr & ~32'(BE_W - 1);
        r_log_data <= w_resp_word;
      end
    end
  end

  assign log_valid = r_log_valid;
  assign log_addr  = r_log_addr;
  assign log_data  = r_log_data;
`endif

endmodule

// File: tb/tb_dm_wait_mem.sv
// Scoreboard bench for dm_wait_mem: DEPTH=16 with two and zero wait states.
module tb_dm_wait_mem;

  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int WC  = 2;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err, init_done;
  logic [31:0] rsp_rdata;

  logic        v0, ready0, rsp_valid0, rsp_err0, init_done0;
  logic [31:0] rsp_rdata0;
  logic [31:0] addr0;
  logic [3:0]  be0;
  logic [31:0] wdata0;

`ifdef DM_WRITE_LOG_EN
  logic        log_valid, log_valid0;
  logic [31:0] log_addr, log_addr0, log_data, log_data0;
`endif

  dm_wait_mem #(.DATA_W(DW), .DEPTH(DEP), .ADDR_BASE(32'h0), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_byteen(req_byteen), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done)
`ifdef DM_WRITE_LOG_EN
    , .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data)
`endif
  );

  dm_wait_mem #(.DATA_W(DW), .DEPTH(DEP), .ADDR_BASE(32'h0), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(v0), .req_ready(ready0), .req_addr(addr0),
    .req_byteen(be0), .req_wdata(wdata0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .init_done(init_done0)
`ifdef DM_WRITE_LOG_EN
    , .log_valid(log_valid0), .log_addr(log_addr0), .log_data(log_data0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per response pulse.
  always @(negedge clk) begin
    if (reset === 1'b1 && rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata %h err %b, required no response", rsp_rdata, rsp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, " rdata"}, rsp_rdata, e.rdata);
        check({e.name, " err"}, 32'(rsp_err), 32'(e.err));
        check({e.name, " latency"}, 32'(cyc), 32'(e.cyc));
        $display("rsp %s rdata=%h err=%0d cycle=%0d", e.name, rsp_rdata, rsp_err, cyc);
      end
    end
  end

`ifdef DM_WRITE_LOG_EN
  always @(negedge clk) begin
    if (log_valid === 1'b1) $display("*%h <= %h", log_addr, log_data);
    if (log_valid0 === 1'b1) $display("*%h <= %h (dut0)", log_addr0, log_data0);
  end
`endif

  // Called at a negedge; drives for one cycle once req_ready is seen.
  task automatic do_req(input string name, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input bit push);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: req_ready %b, required 1", name, req_ready);
      return;
    end
    req_valid  = 1'b1;
    req_addr   = a;
    req_byteen = be;
    req_wdata  = wd;
    if (push) sb.push_back('{exp_rd, exp_err, cyc + WC + 1, name});
    $display("req %s addr=%h be=%b wdata=%h", name, a, be, wd);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d responses outstanding, required 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    req_valid = 1'b0; req_addr = '0; req_byteen = '0; req_wdata = '0;
    v0 = 1'b0; addr0 = '0; be0 = '0; wdata0 = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);

    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_rdata", rsp_rdata, 32'd0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    check("rst init_done", 32'(init_done), 32'd0);

    reset = 1'b1;
    for (int i = 0; i < DEP; i++) begin
      check($sformatf("clr%0d req_ready", i), 32'(req_ready), 32'd0);
      check($sformatf("clr%0d init_done", i), 32'(init_done), 32'd0);
      @(negedge clk);
    end
    check("init_done set", 32'(init_done), 32'd1);
    check("idle req_ready", 32'(req_ready), 32'd1);
    check("dut0 init_done", 32'(init_done0), 32'd1);

    // Zero wait states with request held: accept, respond, accept, ...
    v0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("w0 c%0d rsp_valid", i), 32'(rsp_valid0), 32'(i % 2));
      check($sformatf("w0 c%0d req_ready", i), 32'(ready0), 32'((i + 1) % 2));
      if (rsp_valid0 === 1'b1) begin
        check($sformatf("w0 c%0d rdata", i), rsp_rdata0, 32'd0);
        check($sformatf("w0 c%0d err", i), 32'(rsp_err0), 32'd0);
      end
      $display("w0 cycle %0d ready=%b rsp_valid=%b", i, ready0, rsp_valid0);
      @(negedge clk);
    end
    v0 = 1'b0;

    for (int i = 0; i < DEP; i++)
      do_req($sformatf("rd_zero%0d", i), 32'(i * 4), 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);

    do_req("wr8_full",  32'h08, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);
    do_req("rd8_a",     32'h08, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1);
    do_req("wr8_lane2", 32'h08, 4'b0100, 32'h00AA0000, 32'hDEAABEEF, 1'b0, 1'b1);
    do_req("rd8_b",     32'h08, 4'b0000, 32'h0,        32'hDEAABEEF, 1'b0, 1'b1);
    do_req("rd40_oor",  32'h40, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b1);
    do_req("wr40_oor",  32'h40, 4'b1111, 32'h12345678, 32'h0,        1'b1, 1'b1);
    do_req("rd3c_last", 32'h3C, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1);
    do_req("wr3c_lane0",32'h3C, 4'b0001, 32'hFFFFFF11, 32'h00000011, 1'b0, 1'b1);
    do_req("rd3c",      32'h3C, 4'b0000, 32'h0,        32'h00000011, 1'b0, 1'b1);
    do_req("rd9_unal",  32'h09, 4'b0000, 32'h0,        32'hDEAABEEF, 1'b0, 1'b1);
    do_req("rd_wrap",   32'hFFFFFFFC, 4'b0000, 32'h0,  32'h0,        1'b1, 1'b1);
    drain("oor");
    check("hold rsp_err", 32'(rsp_err), 32'd1);
    check("hold rsp_valid", 32'(rsp_valid), 32'd0);

    do_req("rd0_after_oor", 32'h00, 4'b0000, 32'h0, 32'h0,        1'b0, 1'b1);
    do_req("rd8_c",         32'h08, 4'b0000, 32'h0, 32'hDEAABEEF, 1'b0, 1'b1);
    drain("pre_reset");
    check("hold rsp_rdata", rsp_rdata, 32'hDEAABEEF);
    check("hold rsp_err clr", 32'(rsp_err), 32'd0);

    // Write to 0x4 is abandoned by a reset landing in WAIT.
    do_req("wr4_aborted", 32'h04, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("mid rst rsp_rdata", rsp_rdata, 32'd0);
    check("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid rst req_ready", 32'(req_ready), 32'd0);
    check("mid rst init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    begin
      int n;
      n = 0;
      while (init_done !== 1'b1 && n < 4 * DEP) begin
        @(negedge clk);
        n++;
      end
    end
    check("reinit init_done", 32'(init_done), 32'd1);
    do_req("rd4_after_rst", 32'h04, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
    do_req("rd8_after_rst", 32'h08, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
